// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the execute / EXE-MEM pipeline slice:
//   - DATA_W_DEF : default datapath width (also the MUL iteration count)
//   - ALU_*      : 4-bit ALU operation codes carried on ealuc
//   - mul_state_t: states of the stage's multi-cycle MUL sequencer
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/exe_mem_stage_if.sv
// ---------------------------------------------------------------------------
// exe_mem_stage_if
// Bundles the ID/EXE-side inputs and the EXE/MEM-side outputs of the
// execute stage.
//   slave  modport : used by exe_mem_stage (consumes e*, drives stall and m*)
//   master modport : used by whoever feeds the stage (drives e*, sees m*)
// Signals:
//   ein_valid, ewreg, em2reg, ewmem, ealuc[3:0], ealuimm, edestReg[4:0],
//   eqa, eqb, eimm32                          : ID/EXE register outputs
//   stall                                     : hold upstream this cycle
//   mvalid, mwreg, mm2reg, mwmem, mdestReg, mr, mqb : EXE/MEM register
// ---------------------------------------------------------------------------
interface exe_mem_stage_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              ein_valid;
    logic              ewreg;
    logic              em2reg;
    logic              ewmem;
    logic [3:0]        ealuc;
    logic              ealuimm;
    logic [4:0]        edestReg;
    logic [DATA_W-1:0] eqa;
    logic [DATA_W-1:0] eqb;
    logic [DATA_W-1:0] eimm32;

    logic              stall;
    logic              mvalid;
    logic              mwreg;
    logic              mm2reg;
    logic              mwmem;
    logic [4:0]        mdestReg;
    logic [DATA_W-1:0] mr;
    logic [DATA_W-1:0] mqb;

    modport slave (
        input  ein_valid, ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg,
               eqa, eqb, eimm32,
        output stall, mvalid, mwreg, mm2reg, mwmem, mdestReg, mr, mqb
    );

    modport master (
        output ein_valid, ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg,
               eqa, eqb, eimm32,
        input  stall, mvalid, mwreg, mm2reg, mwmem, mdestReg, mr, mqb
    );

endinterface

// File: rtl/mul_seq.sv
// ---------------------------------------------------------------------------
// mul_seq
// Radix-2 unsigned shift-add multiplier producing the low DATA_W bits of
// a*b in DATA_W iterations, one iteration per clock.
// Ports:
//   clock, resetn : clock, asynchronous active-low reset
//   start         : capture a/b, clear accumulator and counter
//   a, b          : operands (only sampled while start is high)
//   busy          : iterations in progress
//   done          : high during the final iteration; product is complete
//                   from the following cycle until the next start
//   product       : accumulated product
// ---------------------------------------------------------------------------
module mul_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int               CNT_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DATA_W - 1);

    logic              r_busy;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;

    // Multiplicand shifts left and multiplier shifts right, so each step
    // only needs to look at the multiplier's LSB. Bits shifted beyond
    // DATA_W are dropped, which yields the product modulo 2^DATA_W.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_count  <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (r_count == LAST_IT) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_busy && (r_count == LAST_IT);
    assign product = r_acc;

endmodule

// File: rtl/exe_mem_stage.sv
// ---------------------------------------------------------------------------
// exe_mem_stage
// Execute stage plus EXE/MEM pipeline register. Selects operand B, runs the
// ALU and registers result, store data and control into the MEM slot. MUL
// is handed to mul_seq and the stage stalls upstream until it finishes.
// Ports:
//   clock  : pipeline clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : exe_mem_stage_if.slave (ID/EXE inputs, stall, EXE/MEM outputs)
// ---------------------------------------------------------------------------
module exe_mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic            clock,
    input  logic            resetn,
    exe_mem_stage_if.slave  bus
);

    mul_state_t        r_state;
    mul_state_t        w_nextState;

    logic [DATA_W-1:0] w_opB;
    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_aluRes;
    logic              w_isMul;

    logic              w_stall;
    logic              w_mulStart;
    logic              w_loadValid;
    logic              w_useProduct;

    logic              w_mulBusy;
    logic              w_mulDone;
    logic [DATA_W-1:0] w_product;

    logic              r_mvalid;
    logic              r_mwreg;
    logic              r_mm2reg;
    logic              r_mwmem;
    logic [4:0]        r_mdestReg;
    logic [DATA_W-1:0] r_mr;
    logic [DATA_W-1:0] r_mqb;

    assign w_opB   = bus.ealuimm ? bus.eimm32 : bus.eqb;
    assign w_shamt = w_opB[4:0];
    assign w_isMul = bus.ein_valid && (bus.ealuc == ALU_MUL);

    // Single-cycle ALU. MUL and the unused codes give 0 here; the MUL
    // result comes from mul_seq instead.
    always_comb begin
        w_aluRes = '0;
        case (bus.ealuc)
            ALU_ADD:  w_aluRes = bus.eqa + w_opB;
            ALU_SUB:  w_aluRes = bus.eqa - w_opB;
            ALU_AND:  w_aluRes = bus.eqa & w_opB;
            ALU_OR:   w_aluRes = bus.eqa | w_opB;
            ALU_XOR:  w_aluRes = bus.eqa ^ w_opB;
            ALU_SLL:  w_aluRes = bus.eqa << w_shamt;
            ALU_SRL:  w_aluRes = bus.eqa >> w_shamt;
            ALU_SRA:  w_aluRes = $unsigned($signed(bus.eqa) >>> w_shamt);
            ALU_SLT:  w_aluRes = {{(DATA_W-1){1'b0}}, ($signed(bus.eqa) < $signed(w_opB))};
            ALU_SLTU: w_aluRes = {{(DATA_W-1){1'b0}}, (bus.eqa < w_opB)};
            ALU_LUI:  w_aluRes = DATA_W'({w_opB[15:0], 16'h0000});
            default:  w_aluRes = '0;
        endcase
    end

    mul_seq #(
        .DATA_W (DATA_W)
    ) u_mulSeq (
        .clock   (clock),
        .resetn  (resetn),
        .start   (w_mulStart),
        .a       (bus.eqa),
        .b       (w_opB),
        .busy    (w_mulBusy),
        .done    (w_mulDone),
        .product (w_product)
    );

    // MUL sequencer state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state. BUSY also bails out to IDLE if the multiplier is somehow
    // not running, so the pipeline can never stall forever.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_isMul) w_nextState = ST_BUSY;
            ST_BUSY: begin
                if (w_mulDone) begin
                    w_nextState = ST_DONE;
                end else if (!w_mulBusy) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Outputs of the sequencer. The MUL's capture cycle already stalls so
    // the held operands are still valid one cycle later; DONE releases the
    // stall and retires the product together with the held control bits.
    always_comb begin
        w_stall      = 1'b0;
        w_mulStart   = 1'b0;
        w_loadValid  = 1'b0;
        w_useProduct = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall     = w_isMul;
                w_mulStart  = w_isMul;
                w_loadValid = bus.ein_valid && !w_isMul;
            end
            ST_BUSY: w_stall = 1'b1;
            ST_DONE: begin
                w_loadValid  = 1'b1;
                w_useProduct = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates stall so it falls together with the asynchronous reset
    // even while upstream still presents the MUL.
    assign bus.stall = resetn && w_stall;

    // EXE/MEM pipeline register; anything not loaded as a real instruction
    // becomes an all-zero bubble.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_mvalid   <= 1'b0;
            r_mwreg    <= 1'b0;
            r_mm2reg   <= 1'b0;
            r_mwmem    <= 1'b0;
            r_mdestReg <= '0;
            r_mr       <= '0;
            r_mqb      <= '0;
        end else if (w_loadValid) begin
            r_mvalid   <= 1'b1;
            r_mwreg    <= bus.ewreg;
            r_mm2reg   <= bus.em2reg;
            r_mwmem    <= bus.ewmem;
            r_mdestReg <= bus.edestReg;
            r_mr       <= w_useProduct ? w_product : w_aluRes;
            r_mqb      <= bus.eqb;
        end else begin
            r_mvalid   <= 1'b0;
            r_mwreg    <= 1'b0;
            r_mm2reg   <= 1'b0;
            r_mwmem    <= 1'b0;
            r_mdestReg <= '0;
            r_mr       <= '0;
            r_mqb      <= '0;
        end
    end

    assign bus.mvalid   = r_mvalid;
    assign bus.mwreg    = r_mwreg;
    assign bus.mm2reg   = r_mm2reg;
    assign bus.mwmem    = r_mwmem;
    assign bus.mdestReg = r_mdestReg;
    assign bus.mr       = r_mr;
    assign bus.mqb      = r_mqb;

endmodule

// File: tb/tb_exe_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_exe_mem_stage
// Directed testbench for exe_mem_stage: reset, ALU ops, store data,
// multi-cycle MUL, bubbles, reset during MUL and back-to-back MULs.
// ---------------------------------------------------------------------------
module tb_exe_mem_stage;
    import cpu_pkg::*;

    logic clock = 1'b0;
    logic resetn;

    int passCount  = 0;
    int checkCount = 0;

    exe_mem_stage_if #(.DATA_W(32)) bus ();

    exe_mem_stage #(
        .DATA_W (32)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    // Drive one ID/EXE slot onto the interface.
    task automatic applyStimulus(input logic valid, input logic wreg,
                                 input logic m2reg, input logic wmem,
                                 input logic [3:0] aluc, input logic aluimm,
                                 input logic [4:0] dest, input logic [31:0] qa,
                                 input logic [31:0] qb, input logic [31:0] imm);
        bus.ein_valid = valid;
        bus.ewreg     = wreg;
        bus.em2reg    = m2reg;
        bus.ewmem     = wmem;
        bus.ealuc     = aluc;
        bus.ealuimm   = aluimm;
        bus.edestReg  = dest;
        bus.eqa       = qa;
        bus.eqb       = qb;
        bus.eimm32    = imm;
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic stepEdge();
        @(posedge clock);
        #1;
    endtask

    // Step edges while stall is high (bounded); count stall cycles and any
    // valid MEM slot seen after each stalled edge.
    task automatic waitMulStall(output int cycles, output int badValid);
        cycles   = 0;
        badValid = 0;
        while (bus.stall === 1'b1 && cycles < 100) begin
            stepEdge();
            cycles++;
            if (bus.mvalid !== 1'b0) badValid++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        applyStimulus(1, 1, 0, 0, ALU_ADD, 1, 5'd3, 32'd5, 32'd0, 32'd7);
        #2;
        checkCount++;
        if (bus.mvalid !== 1'b0 || bus.mr !== 32'h0 || bus.mwreg !== 1'b0 || bus.mdestReg !== 5'd0) $display("FAIL reset_outputs: mvalid=%b mr=%h mwreg=%b mdestReg=%0d expected all 0", bus.mvalid, bus.mr, bus.mwreg, bus.mdestReg);
        else passCount++;
        #6;
        checkCount++;
        if (bus.mvalid !== 1'b0 || bus.mr !== 32'h0) $display("FAIL reset_across_edge: mvalid=%b mr=%h expected 0/0", bus.mvalid, bus.mr);
        else passCount++;
        #4;
        resetn = 1'b1;
        #1;
        checkCount++;
        if (bus.mvalid !== 1'b0 || bus.stall !== 1'b0) $display("FAIL reset_release: mvalid=%b stall=%b expected 0/0", bus.mvalid, bus.stall);
        else passCount++;
    endtask

    task automatic test_addi();
        applyStimulus(1, 1, 0, 0, ALU_ADD, 1, 5'd3, 32'd5, 32'd0, 32'd7);
        #1;
        checkCount++;
        if (bus.stall !== 1'b0) $display("FAIL addi_stall: stall=%b expected 0", bus.stall);
        else passCount++;
        stepEdge();
        checkCount++;
        if (bus.mr !== 32'd12 || bus.mdestReg !== 5'd3 || bus.mwreg !== 1'b1 || bus.mvalid !== 1'b1) $display("FAIL addi_result: mr=%h dest=%0d mwreg=%b mvalid=%b expected 0000000c/3/1/1", bus.mr, bus.mdestReg, bus.mwreg, bus.mvalid);
        else passCount++;
    endtask

    task automatic test_sub_store();
        applyStimulus(1, 1, 0, 0, ALU_SUB, 0, 5'd4, 32'd0, 32'd1, 32'd0);
        stepEdge();
        checkCount++;
        if (bus.mr !== 32'hFFFFFFFF || bus.mvalid !== 1'b1) $display("FAIL sub_wrap: mr=%h mvalid=%b expected ffffffff/1", bus.mr, bus.mvalid);
        else passCount++;
        applyStimulus(1, 0, 0, 1, ALU_ADD, 1, 5'd0, 32'h100, 32'hDEAD, 32'd8);
        stepEdge();
        checkCount++;
        if (bus.mqb !== 32'hDEAD || bus.mr !== 32'h108 || bus.mwmem !== 1'b1 || bus.mwreg !== 1'b0) $display("FAIL store_data: mqb=%h mr=%h mwmem=%b mwreg=%b expected 0000dead/00000108/1/0", bus.mqb, bus.mr, bus.mwmem, bus.mwreg);
        else passCount++;
    endtask

    task automatic test_alu_ops();
        logic [3:0]  opTab  [9] = '{ALU_SRA, ALU_SRL, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_XOR, ALU_LUI, ALU_AND, 4'd13};
        logic        immTab [9] = '{1, 1, 0, 0, 1, 0, 1, 0, 0};
        logic [31:0] qaTab  [9] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hF0F0, 32'h0, 32'hF0F0, 32'h1234};
        logic [31:0] qbTab  [9] = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h0, 32'hFF00, 32'h0, 32'hFF00, 32'h5678};
        logic [31:0] immVal [9] = '{32'd4, 32'd4, 32'h0, 32'h0, 32'd31, 32'h0, 32'h1234, 32'h0, 32'h0};
        logic [31:0] expTab [9] = '{32'hF8000000, 32'h08000000, 32'h1, 32'h0, 32'h80000000, 32'h0FF0, 32'h12340000, 32'hF000, 32'h0};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 1, 0, 0, opTab[i], immTab[i], 5'(i + 1), qaTab[i], qbTab[i], immVal[i]);
            stepEdge();
            checkCount++;
            if (bus.mr !== expTab[i] || bus.mvalid !== 1'b1) $display("FAIL alu_op%0d (aluc=%0d): mr=%h mvalid=%b expected %h/1", i, opTab[i], bus.mr, bus.mvalid, expTab[i]);
            else passCount++;
        end
    endtask

    task automatic test_mul();
        int cycles;
        int badValid;
        applyStimulus(1, 1, 0, 0, ALU_MUL, 0, 5'd7, 32'h00010003, 32'd5, 32'd0);
        #1;
        checkCount++;
        if (bus.stall !== 1'b1) $display("FAIL mul_stall_entry: stall=%b expected 1", bus.stall);
        else passCount++;
        waitMulStall(cycles, badValid);
        checkCount++;
        if (cycles !== 33) $display("FAIL mul_stall_len: stall cycles=%0d expected 33", cycles);
        else passCount++;
        checkCount++;
        if (badValid !== 0) $display("FAIL mul_bubbles: valid slots during stall=%0d expected 0", badValid);
        else passCount++;
        stepEdge();
        checkCount++;
        if (bus.mr !== 32'h0005000F || bus.mvalid !== 1'b1 || bus.mdestReg !== 5'd7) $display("FAIL mul_result: mr=%h mvalid=%b dest=%0d expected 0005000f/1/7", bus.mr, bus.mvalid, bus.mdestReg);
        else passCount++;
        applyStimulus(1, 1, 0, 0, ALU_ADD, 0, 5'd9, 32'd2, 32'd3, 32'd0);
        #1;
        checkCount++;
        if (bus.stall !== 1'b0) $display("FAIL mul_follow_stall: stall=%b expected 0", bus.stall);
        else passCount++;
        stepEdge();
        checkCount++;
        if (bus.mr !== 32'd5 || bus.mvalid !== 1'b1 || bus.mdestReg !== 5'd9) $display("FAIL mul_follow_add: mr=%h mvalid=%b dest=%0d expected 00000005/1/9", bus.mr, bus.mvalid, bus.mdestReg);
        else passCount++;
    endtask

    task automatic test_bubble();
        applyStimulus(0, 1, 0, 1, ALU_MUL, 0, 5'd6, 32'd3, 32'd4, 32'd0);
        #1;
        checkCount++;
        if (bus.stall !== 1'b0) $display("FAIL bubble_stall: stall=%b expected 0", bus.stall);
        else passCount++;
        stepEdge();
        checkCount++;
        if (bus.mvalid !== 1'b0 || bus.mwreg !== 1'b0 || bus.mwmem !== 1'b0) $display("FAIL bubble_load: mvalid=%b mwreg=%b mwmem=%b expected 0/0/0", bus.mvalid, bus.mwreg, bus.mwmem);
        else passCount++;
        applyStimulus(1, 1, 0, 0, ALU_OR, 0, 5'd2, 32'h10, 32'h01, 32'd0);
        #1;
        checkCount++;
        if (bus.stall !== 1'b0) $display("FAIL bubble_no_mul: stall=%b expected 0", bus.stall);
        else passCount++;
        stepEdge();
        checkCount++;
        if (bus.mr !== 32'h11 || bus.mvalid !== 1'b1) $display("FAIL bubble_next_or: mr=%h mvalid=%b expected 00000011/1", bus.mr, bus.mvalid);
        else passCount++;
    endtask

    task automatic test_reset_mid_mul();
        applyStimulus(1, 1, 0, 0, ALU_MUL, 0, 5'd8, 32'd3, 32'd4, 32'd0);
        for (int i = 0; i < 9; i++) stepEdge();
        checkCount++;
        if (bus.stall !== 1'b1) $display("FAIL midmul_stall: stall=%b expected 1", bus.stall);
        else passCount++;
        #2;
        resetn = 1'b0;
        #1;
        checkCount++;
        if (bus.stall !== 1'b0 || bus.mvalid !== 1'b0 || bus.mr !== 32'h0 || bus.mwreg !== 1'b0) $display("FAIL midmul_reset: stall=%b mvalid=%b mr=%h mwreg=%b expected 0/0/0/0", bus.stall, bus.mvalid, bus.mr, bus.mwreg);
        else passCount++;
        applyStimulus(1, 1, 0, 0, ALU_ADD, 0, 5'd4, 32'd10, 32'd20, 32'd0);
        #1;
        resetn = 1'b1;
        #1;
        checkCount++;
        if (bus.stall !== 1'b0 || bus.mvalid !== 1'b0) $display("FAIL midmul_release: stall=%b mvalid=%b expected 0/0", bus.stall, bus.mvalid);
        else passCount++;
        stepEdge();
        checkCount++;
        if (bus.mr !== 32'd30 || bus.mvalid !== 1'b1 || bus.mdestReg !== 5'd4) $display("FAIL midmul_add: mr=%h mvalid=%b dest=%0d expected 0000001e/1/4", bus.mr, bus.mvalid, bus.mdestReg);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int cycles;
        int badValid;
        applyStimulus(1, 1, 0, 0, ALU_MUL, 0, 5'd10, 32'd3, 32'd4, 32'd0);
        #1;
        waitMulStall(cycles, badValid);
        checkCount++;
        if (cycles !== 33 || badValid !== 0) $display("FAIL b2b_first_stall: cycles=%0d bubbles_bad=%0d expected 33/0", cycles, badValid);
        else passCount++;
        stepEdge();
        checkCount++;
        if (bus.mr !== 32'd12 || bus.mvalid !== 1'b1 || bus.mdestReg !== 5'd10) $display("FAIL b2b_first_result: mr=%h mvalid=%b dest=%0d expected 0000000c/1/10", bus.mr, bus.mvalid, bus.mdestReg);
        else passCount++;
        applyStimulus(1, 1, 0, 0, ALU_MUL, 1, 5'd11, 32'd6, 32'd0, 32'd7);
        #1;
        waitMulStall(cycles, badValid);
        checkCount++;
        if (cycles !== 33 || badValid !== 0) $display("FAIL b2b_second_stall: cycles=%0d bubbles_bad=%0d expected 33/0", cycles, badValid);
        else passCount++;
        stepEdge();
        checkCount++;
        if (bus.mr !== 32'd42 || bus.mvalid !== 1'b1 || bus.mdestReg !== 5'd11) $display("FAIL b2b_second_result: mr=%h mvalid=%b dest=%0d expected 0000002a/1/11", bus.mr, bus.mvalid, bus.mdestReg);
        else passCount++;
        applyStimulus(0, 0, 0, 0, ALU_ADD, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        stepEdge();
        checkCount++;
        if (bus.mvalid !== 1'b0) $display("FAIL b2b_no_duplicate: mvalid=%b expected 0", bus.mvalid);
        else passCount++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] exe_mem_stage directed test start");
        test_reset();
        test_addi();
        test_sub_store();
        test_alu_ops();
        test_mul();
        test_bubble();
        test_reset_mid_mul();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
